// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite codes, FSM states and byte-lane helper
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } ahb_state_e;

    // Little-endian byte enables for a naturally aligned transfer
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << a;
            HSIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// rtl/ahb_slv_mem.sv - word memory with byte enables, sync clear, async read
module ahb_slv_mem #(
    parameter int MEM_DEPTH = 64,
    parameter int AW        = 6
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_sram_slv.sv
// rtl/ahb_sram_slv.sv - AHB-Lite SRAM responder with wait states and ERROR response
module ahb_sram_slv
    import ahb_pkg::*;
#(
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hready_resp,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int          AW          = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] ADDR_LIMIT  = 32'(MEM_DEPTH * 4);
    localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_STATES);

    ahb_state_e    state_q;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [3:0]    be_q;
    logic [3:0]    wcnt_q;
    logic          ready_q;
    logic [1:0]    resp_q;

    logic          accept;
    logic          legal;
    logic          complete;
    logic          done;
    logic [31:0]   mem_rdata;
    logic          unused_ok;

    assign unused_ok = ^hburst;

    assign accept = hsel && hready && (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);
    assign legal  = (haddr < ADDR_LIMIT) && (hsize <= HSIZE_WORD)
                 && !((hsize == HSIZE_HALF) && haddr[0])
                 && !((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));

    assign complete = (state_q == ST_DATA) && (wcnt_q == 4'd0);
    // Cycles in which the bus may hand us the next address phase
    assign done     = (state_q == ST_IDLE) || (state_q == ST_ERR2) || complete;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            be_q    <= 4'b0000;
            wcnt_q  <= 4'd0;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
        end else if (done) begin
            if (accept) begin
                addr_q  <= haddr[AW+1:2];
                write_q <= hwrite;
                be_q    <= lane_mask(hsize, haddr[1:0]);
                if (legal) begin
                    state_q <= ST_DATA;
                    wcnt_q  <= WAIT_INIT;
                    ready_q <= (WAIT_INIT == 4'd0);
                    resp_q  <= HRESP_OKAY;
                end else begin
                    state_q <= ST_ERR1;
                    wcnt_q  <= 4'd0;
                    ready_q <= 1'b0;
                    resp_q  <= HRESP_ERROR;
                end
            end else begin
                state_q <= ST_IDLE;
                ready_q <= 1'b1;
                resp_q  <= HRESP_OKAY;
            end
        end else begin
            case (state_q)
                ST_DATA: begin
                    wcnt_q  <= wcnt_q - 4'd1;
                    ready_q <= (wcnt_q == 4'd1);
                end
                ST_ERR1: begin
                    state_q <= ST_ERR2;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    ahb_slv_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk    (hclk),
        .resetn (hresetn),
        .we     (complete && write_q),
        .be     (be_q),
        .addr   (addr_q),
        .wdata  (hwdata),
        .rdata  (mem_rdata)
    );

    assign hready_resp = ready_q;
    assign hresp       = resp_q;
    assign hrdata      = (complete && !write_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slv.sv
// tb/tb_ahb_sram_slv.sv - scoreboard bench for ahb_sram_slv (WAIT_STATES 0 and 2)
module tb_ahb_sram_slv;

    typedef struct {
        string       name;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [2:0]  hburst = 3'b000;
    logic [31:0] hwdata = '0;
    logic        stall = 1'b0;
    logic        sel = 1'b0;

    logic        rdy0, rdy2;
    logic [1:0]  resp0, resp2;
    logic [31:0] rd0, rd2;

    wire         bus_hready = (sel ? rdy2 : rdy0) & ~stall;
    wire [1:0]   m_resp     = sel ? resp2 : resp0;
    wire [31:0]  m_rdata    = sel ? rd2 : rd0;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ahb_sram_slv #(.MEM_DEPTH(64), .WAIT_STATES(0)) u_dut0 (
        .hclk(clk), .hresetn(hresetn), .hsel(hsel & ~sel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hready(bus_hready), .hready_resp(rdy0),
        .hresp(resp0), .hrdata(rd0)
    );

    ahb_sram_slv #(.MEM_DEPTH(64), .WAIT_STATES(2)) u_dut2 (
        .hclk(clk), .hresetn(hresetn), .hsel(hsel & sel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hready(bus_hready), .hready_resp(rdy2),
        .hresp(resp2), .hrdata(rd2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: tracks data phases from bus signals and scores each beat
    logic in_data = 1'b0;
    logic have_cur = 1'b0;
    int   wait_cnt = 0;
    exp_t cur;

    always @(negedge clk) begin
        logic busy;
        if (!hresetn) begin
            in_data  = 1'b0;
            have_cur = 1'b0;
        end else begin
            busy = 1'b0;
            if (in_data) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=beat expected=none");
                        cur = '{name: "unexpected", resp: 2'b00, rdata: 32'h0, waits: 0};
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    have_cur = 1'b1;
                    wait_cnt = 0;
                end
                if (!(sel ? rdy2 : rdy0)) begin
                    wait_cnt++;
                    chk({cur.name, "_wait_resp"}, {30'h0, m_resp}, {30'h0, cur.resp});
                    chk({cur.name, "_wait_rdata"}, m_rdata, 32'h0);
                    busy = 1'b1;
                end else begin
                    chk({cur.name, "_resp"}, {30'h0, m_resp}, {30'h0, cur.resp});
                    chk({cur.name, "_rdata"}, m_rdata, cur.rdata);
                    chk({cur.name, "_waits"}, wait_cnt, cur.waits);
                    have_cur = 1'b0;
                end
            end
            in_data = busy | (hsel & htrans[1] & bus_hready);
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus_hready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL timeout actual=hready_low expected=hready_high");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    task automatic go_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic xfer(input string nm, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd,
                        input logic [1:0] er, input logic [31:0] erd, input int ew);
        exp_q.push_back('{name: nm, resp: er, rdata: erd, waits: ew});
        addr_phase(wr, a, sz);
        wait_ready();
        go_idle();
        hwdata = wd;
        wait_ready();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hready", {31'h0, rdy0}, 32'h1);
        chk("rst_hresp", {30'h0, resp0}, 32'h0);
        chk("rst_hrdata", rd0, 32'h0);
        hresetn = 1'b1;
        @(posedge clk);
        #1;

        xfer("wr_word10", 1, 32'h10, 3'b010, 32'hDEAD_BEEF, 2'b00, 32'h0, 0);
        xfer("rd_word10", 0, 32'h10, 3'b010, 32'h0, 2'b00, 32'hDEAD_BEEF, 0);
        xfer("wr_byte11", 1, 32'h11, 3'b000, 32'h0000_AB00, 2'b00, 32'h0, 0);
        xfer("rd_after_byte", 0, 32'h10, 3'b010, 32'h0, 2'b00, 32'hDEAD_ABEF, 0);
        xfer("err_range", 0, 32'h100, 3'b010, 32'h0, 2'b01, 32'h0, 1);
        xfer("err_unalign", 0, 32'h02, 3'b010, 32'h0, 2'b01, 32'h0, 1);
        xfer("rd_after_err", 0, 32'h10, 3'b010, 32'h0, 2'b00, 32'hDEAD_ABEF, 0);
        xfer("err_half_odd", 1, 32'h13, 3'b001, 32'hFFFF_FFFF, 2'b01, 32'h0, 1);
        xfer("err_size", 0, 32'h10, 3'b011, 32'h0, 2'b01, 32'h0, 1);
        xfer("wr_half16", 1, 32'h16, 3'b001, 32'h1234_0000, 2'b00, 32'h0, 0);
        xfer("rd_word14", 0, 32'h14, 3'b010, 32'h0, 2'b00, 32'h1234_0000, 0);

        // Back-to-back write then read of the same word
        exp_q.push_back('{name: "pipe_wr18", resp: 2'b00, rdata: 32'h0, waits: 0});
        exp_q.push_back('{name: "pipe_rd18", resp: 2'b00, rdata: 32'hCAFE_F00D, waits: 0});
        addr_phase(1, 32'h18, 3'b010);
        wait_ready();
        addr_phase(0, 32'h18, 3'b010);
        hwdata = 32'hCAFE_F00D;
        wait_ready();
        go_idle();
        wait_ready();

        // Another slave holds the bus: address phase must not be taken
        stall = 1'b1;
        addr_phase(0, 32'h18, 3'b010);
        repeat (3) begin
            @(negedge clk);
            chk("stall_hready", {31'h0, rdy0}, 32'h1);
            chk("stall_hrdata", rd0, 32'h0);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        xfer("rd_after_stall", 0, 32'h18, 3'b010, 32'h0, 2'b00, 32'hCAFE_F00D, 0);

        // Reset during a write data phase
        addr_phase(1, 32'h1C, 3'b010);
        wait_ready();
        go_idle();
        hwdata  = 32'h55AA_55AA;
        hresetn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_hready", {31'h0, rdy0}, 32'h1);
        chk("midrst_hresp", {30'h0, resp0}, 32'h0);
        chk("midrst_hrdata", rd0, 32'h0);
        hresetn = 1'b1;
        @(posedge clk);
        #1;
        xfer("rd_1c_after_rst", 0, 32'h1C, 3'b010, 32'h0, 2'b00, 32'h0, 0);
        xfer("rd_10_after_rst", 0, 32'h10, 3'b010, 32'h0, 2'b00, 32'h0, 0);

        sel = 1'b1;
        @(posedge clk);
        #1;
        xfer("ws2_wr20", 1, 32'h20, 3'b010, 32'h0BAD_F00D, 2'b00, 32'h0, 2);
        xfer("ws2_rd20", 0, 32'h20, 3'b010, 32'h0, 2'b00, 32'h0BAD_F00D, 2);
        xfer("ws2_err", 0, 32'h100, 3'b010, 32'h0, 2'b01, 32'h0, 1);

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'h0);
        chk("no_open_beat", {31'h0, have_cur}, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
